// File: rtl/dbg_ctrl_pkg.sv
// Shared types and constants for the debug register-dump controller.
//   state_t     : controller FSM states
//   tag_t       : in-flight read tag {addr,last} travelling with the read latency
//   rsp_entry_t : response FIFO entry {addr,data,last}
//   next_sel()  : register index increment with wrap at NUM_REGS
//   cmd_count() : maps a command count of 0 to NUM_REGS
package dbg_ctrl_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SEL_W    = $clog2(NUM_REGS);
  localparam int unsigned CNT_W    = SEL_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    HALT_WAIT,
    ISSUE,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [SEL_W-1:0] addr;
    logic             last;
  } tag_t;

  typedef struct packed {
    logic [SEL_W-1:0]  addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } rsp_entry_t;

  // Explicit wrap so a non power-of-two register count still cycles correctly.
  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] cur);
    if (cur == SEL_W'(NUM_REGS - 1)) return '0;
    return cur + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] cmd_count(input logic [CNT_W-1:0] cnt);
    return (cnt == '0) ? CNT_W'(NUM_REGS) : cnt;
  endfunction

endpackage

// File: rtl/dbg_rsp_fifo.sv
// Response FIFO, first-word-fall-through.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : synchronous clear (priority over push/pop)
//   push       : write push_data
//   pop        : consume head (ignored when empty)
//   head       : current head entry, valid while not_empty
//   not_empty  : head valid
//   count      : number of stored entries (0..DEPTH)
// Push+pop on the same edge is legal at full and at empty; count is unchanged
// at full, and at empty the pop is ignored so the entry is stored.
module dbg_rsp_fifo
  import dbg_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  rsp_entry_t               push_data,
  input  logic                     pop,
  output rsp_entry_t               head,
  output logic                     not_empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  rsp_entry_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   cnt_q;
  logic          pop_en;
  logic          full;

  assign full      = (cnt_q == (PW + 1)'(DEPTH));
  assign pop_en    = pop && (cnt_q != '0);
  assign not_empty = (cnt_q != '0);
  assign head      = mem[rd_ptr];
  assign count     = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_en) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop_en})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; entries are only observed behind not_empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // The controller's credit check must make a write into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop_en && !flush));

endmodule

// File: rtl/dbg_reg_dump_ctrl.sv
// Debug register-file dump controller.
// Accepts {start reg, count}, requests a core halt, then walks reg_sel_o
// through the core debug port, captures data_reg_i RD_LATENCY cycles after
// each select and streams {addr,data,last} responses through a small FIFO.
//   clk, rst_i                  : clock, asynchronous active-high reset
//   cmd_valid_i/ready_o         : command handshake (ready only in IDLE)
//   cmd_addr_i, cmd_cnt_i       : first register, register count (0 = NUM_REGS)
//   abort_i                     : cancel active command, flush everything
//   halt_req_o, halted_i        : core halt request / acknowledge
//   reg_sel_o, data_reg_i       : core debug register select / read data
//   rsp_valid_o/ready_i         : response handshake (FIFO head)
//   rsp_addr_o/data_o/last_o    : response payload
//   busy_o                      : controller not IDLE
module dbg_reg_dump_ctrl
  import dbg_ctrl_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [SEL_W-1:0]  cmd_addr_i,
  input  logic [CNT_W-1:0]  cmd_cnt_i,
  input  logic              abort_i,
  output logic              halt_req_o,
  input  logic              halted_i,
  output logic [SEL_W-1:0]  reg_sel_o,
  input  logic [DATA_W-1:0] data_reg_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [SEL_W-1:0]  rsp_addr_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_last_o,
  output logic              busy_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_t           state_q;
  state_t           state_d;
  logic [SEL_W-1:0] cur_q;
  logic [SEL_W-1:0] sel_q;
  logic [CNT_W-1:0] remaining_q;

  logic             issue;
  logic             last_issue;
  logic             flush;
  logic [CW-1:0]    fifo_count;
  logic [CW-1:0]    inflight;
  logic [CW:0]      credit_used;
  tag_t             issue_tag;
  tag_t             wr_tag;
  logic             fifo_push;
  rsp_entry_t       wr_entry;
  rsp_entry_t       head;
  logic             fifo_not_empty;

  assign flush       = abort_i && (state_q != IDLE);
  assign last_issue  = (remaining_q == CNT_W'(1));
  // Entries already queued plus reads still in the latency pipe must fit the
  // FIFO, so every issued read is guaranteed a slot when its data arrives.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue       = (state_q == ISSUE) && halted_i && !abort_i &&
                       (credit_used < (CW + 1)'(FIFO_DEPTH));
  assign issue_tag   = '{addr: cur_q, last: last_issue};

  // The select reaches the core in the issue cycle itself so that a zero
  // latency read can be captured on the same edge; otherwise it holds.
  assign reg_sel_o   = issue ? cur_q : sel_q;

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign halt_req_o  = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (cmd_valid_i) state_d = HALT_WAIT;
      HALT_WAIT: if (halted_i) state_d = ISSUE;
      ISSUE:     if (issue && last_issue) state_d = DRAIN;
      DRAIN:     if (inflight == '0 && fifo_count == '0) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      sel_q       <= '0;
      remaining_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cmd_valid_i) begin
        cur_q       <= cmd_addr_i;
        remaining_q <= cmd_count(cmd_cnt_i);
      end else if (issue) begin
        cur_q       <= next_sel(cur_q);
        remaining_q <= remaining_q - 1'b1;
        sel_q       <= cur_q;
      end
    end
  end

  generate
    if (RD_LATENCY == 0) begin : g_lat0
      assign inflight  = '0;
      assign fifo_push = issue;
      assign wr_tag    = issue_tag;
    end else begin : g_pipe
      tag_t                  tag_q [RD_LATENCY];
      logic [RD_LATENCY-1:0] vld_q;

      always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
          vld_q <= '0;
          for (int unsigned i = 0; i < RD_LATENCY; i++) tag_q[i] <= '0;
        end else if (flush) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= issue;
          tag_q[0] <= issue_tag;
          for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            tag_q[i] <= tag_q[i-1];
          end
        end
      end

      always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(vld_q[i]);
      end

      assign fifo_push = vld_q[RD_LATENCY-1];
      assign wr_tag    = tag_q[RD_LATENCY-1];
    end
  endgenerate

  assign wr_entry = '{addr: wr_tag.addr, data: data_reg_i, last: wr_tag.last};

  dbg_rsp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst_i),
    .flush     (flush),
    .push      (fifo_push),
    .push_data (wr_entry),
    .pop       (rsp_ready_i),
    .head      (head),
    .not_empty (fifo_not_empty),
    .count     (fifo_count)
  );

  assign rsp_valid_o = fifo_not_empty;
  assign rsp_addr_o  = head.addr;
  assign rsp_data_o  = head.data;
  assign rsp_last_o  = head.last;

endmodule

// File: tb/tb_dbg_reg_dump_ctrl.sv
// Testbench for dbg_reg_dump_ctrl (RD_LATENCY=1, FIFO_DEPTH=4, 32 registers).
// A core model returns model_data(sel) one cycle after the select; the bench
// keeps a queue of expected responses derived from each command and checks
// every response handshake against it, plus directed literal checks.
module tb_dbg_reg_dump_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [4:0]  cmd_addr_i;
  logic [5:0]  cmd_cnt_i;
  logic        abort_i;
  logic        halt_req_o;
  logic        halted_i;
  logic [4:0]  reg_sel_o;
  logic [31:0] data_reg_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [4:0]  rsp_addr_o;
  logic [31:0] rsp_data_o;
  logic        rsp_last_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        last;
  } rsp_t;

  rsp_t        exp_q[$];
  int          hs_count;
  int          first_cyc;
  int          last_cyc;
  logic [4:0]  seen_addr [64];
  logic        seen_last [64];
  logic [31:0] seen_data [64];
  logic [4:0]  sel_d;

  dbg_reg_dump_ctrl #(
    .RD_LATENCY (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_cnt_i   (cmd_cnt_i),
    .abort_i     (abort_i),
    .halt_req_o  (halt_req_o),
    .halted_i    (halted_i),
    .reg_sel_o   (reg_sel_o),
    .data_reg_i  (data_reg_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_addr_o  (rsp_addr_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_last_o  (rsp_last_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model_data(input int unsigned i);
    return 32'hD000_0000 | (i * 32'h11);
  endfunction

  // Core debug port: data follows the select with one cycle of latency.
  always @(posedge clk) sel_d <= reg_sel_o;
  assign data_reg_i = model_data(32'(sel_d));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired got 0 expected 1", name);
  endtask

  // Every response handshake is checked against the expected stream.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (!busy_o) chk("idle_no_rsp", 64'(rsp_valid_o), 64'd0);
      if (rsp_valid_o && rsp_ready_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got addr %0d expected none", rsp_addr_o);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          chk("rsp_addr", 64'(rsp_addr_o), 64'(e.addr));
          chk("rsp_data", 64'(rsp_data_o), 64'(e.data));
          chk("rsp_last", 64'(rsp_last_o), 64'(e.last));
        end
        if (hs_count < 64) begin
          seen_addr[hs_count] = rsp_addr_o;
          seen_last[hs_count] = rsp_last_o;
          seen_data[hs_count] = rsp_data_o;
        end
        if (hs_count == 0) first_cyc = cyc;
        last_cyc = cyc;
        hs_count++;
      end
    end
  end

  // Called at posedge+1 with the controller idle; returns at posedge+1.
  task automatic send_cmd(input int unsigned addr, input int unsigned cnt);
    int unsigned n;
    rsp_t e;
    n = (cnt == 0) ? 32 : cnt;
    for (int unsigned k = 0; k < n; k++) begin
      e.addr = 5'((addr + k) % 32);
      e.data = model_data((addr + k) % 32);
      e.last = (k == n - 1);
      exp_q.push_back(e);
    end
    hs_count    = 0;
    cmd_addr_i  = 5'(addr);
    cmd_cnt_i   = 6'(cnt);
    cmd_valid_i = 1'b1;
    @(posedge clk);
    #1 cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, output int idle_cyc);
    idle_cyc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy_o) begin
        idle_cyc = cyc;
        break;
      end
    end
    if (idle_cyc < 0) timeout(name);
  endtask

  task automatic wait_sel(input string name, input logic [4:0] v);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy_o && reg_sel_o == v) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) timeout(name);
  endtask

  task automatic check_idle(input string name, input bit with_sel);
    chk({name, "_cmd_ready"}, 64'(cmd_ready_o), 64'd1);
    chk({name, "_halt_req"},  64'(halt_req_o),  64'd0);
    chk({name, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
    chk({name, "_busy"},      64'(busy_o),      64'd0);
    if (with_sel) chk({name, "_reg_sel"}, 64'(reg_sel_o), 64'd0);
  endtask

  initial begin
    int  idle_cyc;
    bit  seen_req;

    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_cnt_i   = '0;
    abort_i     = 1'b0;
    halted_i    = 1'b0;
    rsp_ready_i = 1'b1;
    hs_count    = 0;
    first_cyc   = 0;
    last_cyc    = 0;
    @(negedge clk);
    check_idle("reset", 1'b1);
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(posedge clk);
    #1;

    // 1: single register, halt acknowledged two cycles after request
    send_cmd(3, 1);
    seen_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (halt_req_o) begin
        seen_req = 1'b1;
        break;
      end
    end
    if (!seen_req) timeout("t1_halt_req");
    repeat (2) @(posedge clk);
    #1 halted_i = 1'b1;
    wait_idle("t1_idle", idle_cyc);
    chk("t1_count", 64'(hs_count), 64'd1);
    chk("t1_addr",  64'(seen_addr[0]), 64'd3);
    chk("t1_data",  64'(seen_data[0]), 64'hD000_0033);
    chk("t1_last",  64'(seen_last[0]), 64'd1);
    @(negedge clk);
    check_idle("t1_after", 1'b0);

    // 2: full dump (count 0), one response per cycle
    @(posedge clk);
    #1 send_cmd(0, 0);
    wait_idle("t2_idle", idle_cyc);
    chk("t2_count", 64'(hs_count), 64'd32);
    chk("t2_back_to_back", 64'(last_cyc - first_cyc), 64'd31);
    chk("t2_last_addr", 64'(seen_addr[31]), 64'd31);
    chk("t2_last_flag", 64'(seen_last[31]), 64'd1);
    chk("t2_first_data", 64'(seen_data[0]), 64'hD000_0000);

    // 3: wrap past the top register
    @(posedge clk);
    #1 send_cmd(30, 4);
    wait_idle("t3_idle", idle_cyc);
    chk("t3_count", 64'(hs_count), 64'd4);
    chk("t3_a0", 64'(seen_addr[0]), 64'd30);
    chk("t3_a1", 64'(seen_addr[1]), 64'd31);
    chk("t3_a2", 64'(seen_addr[2]), 64'd0);
    chk("t3_a3", 64'(seen_addr[3]), 64'd1);
    chk("t3_last2", 64'(seen_last[2]), 64'd0);
    chk("t3_last3", 64'(seen_last[3]), 64'd1);
    chk("t3_halt_drop", 64'((idle_cyc > last_cyc) && (idle_cyc <= last_cyc + 2)), 64'd1);

    // 4: back-pressure: issue stops after FIFO_DEPTH reads
    @(posedge clk);
    #1 rsp_ready_i = 1'b0;
    send_cmd(12, 10);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("t4_sel_stall",  64'(reg_sel_o),   64'd15);
    chk("t4_head_valid", 64'(rsp_valid_o), 64'd1);
    chk("t4_head_addr",  64'(rsp_addr_o),  64'd12);
    chk("t4_no_hs",      64'(hs_count),    64'd0);
    @(posedge clk);
    #1 rsp_ready_i = 1'b1;
    wait_idle("t4_idle", idle_cyc);
    chk("t4_count", 64'(hs_count), 64'd10);
    chk("t4_last_addr", 64'(seen_addr[9]), 64'd21);

    // abort while idle has no effect
    @(posedge clk);
    #1 abort_i = 1'b1;
    @(posedge clk);
    #1 abort_i = 1'b0;
    @(negedge clk);
    check_idle("idle_abort", 1'b0);

    // 5: abort after the fifth issue
    @(posedge clk);
    #1 send_cmd(0, 10);
    wait_sel("t5_sel4", 5'd4);
    @(posedge clk);
    #1 abort_i = 1'b1;
    @(posedge clk);
    #1 abort_i = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_idle("t5_abort", 1'b0);
    repeat (4) @(negedge clk);
    chk("t5_stays_idle", 64'(busy_o), 64'd0);

    // 6: halt drop pauses issue without loss, then reset mid dump
    @(posedge clk);
    #1 send_cmd(5, 20);
    wait_sel("t6_sel8", 5'd8);
    @(posedge clk);
    #1 halted_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_sel_hold", 64'(reg_sel_o), 64'd8);
    end
    @(posedge clk);
    #1 halted_i = 1'b1;
    wait_sel("t6_sel12", 5'd12);
    chk("t6_in_order", 64'(seen_addr[0]), 64'd5);
    @(posedge clk);
    #1 rst_i = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_idle("t6_reset", 1'b1);
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check_idle("t6_post_reset", 1'b1);

    // recovery after reset
    @(posedge clk);
    #1 send_cmd(7, 2);
    wait_idle("t7_idle", idle_cyc);
    chk("t7_count", 64'(hs_count), 64'd2);
    chk("t7_a1", 64'(seen_addr[1]), 64'd8);
    chk("t7_d1", 64'(seen_data[1]), 64'hD000_0088);
    chk("exp_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
